// File: rtl/iwb_pkg.sv
// Shared types and bank-mapping helpers for the interleaved window buffer.
package iwb_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } iwb_state_e;

  // Word address of pixel (x,y) inside its bank; truncating division keeps
  // slightly negative (padded) coordinates at address 0.
  function automatic int bank_addr(int x, int y, int win, int bw);
    return (y / win) * bw + x / win;
  endfunction

  // Bank column/row index owning coordinate x.
  function automatic int bank_sel(int x, int win);
    return x % win;
  endfunction

endpackage

// File: rtl/iwb_bank.sv
// One interleave bank: simple dual-port RAM, registered read with enable.
// Contents are deliberately not reset.
module iwb_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 49,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // read port, held when the pipeline stalls
  always_ff @(posedge clk)
    if (re) rdata <= mem[raddr];

endmodule

// File: rtl/interleaved_window_buffer.sv
// Frame buffer storing one raster frame across WIN*WIN interleaved banks and
// returning any WIN x WIN window per request through a 2-stage pipeline.
// Optional feature macro: IWB_ZERO_PAD_EN (signed origins, zero taps outside
// the frame).
module interleaved_window_buffer
  import iwb_pkg::*;
#(
  parameter int WIN    = 5,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int D_SIZE = 16,
  parameter int CH     = 1,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H),
`ifdef IWB_ZERO_PAD_EN
  localparam int CW = XW + 1,
  localparam int RW = YW + 1
`else
  localparam int CW = XW,
  localparam int RW = YW
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CH*D_SIZE-1:0]         wr_data,
  output logic                         frame_full,
  input  logic                         frame_release,
  input  logic                         rq_valid,
  output logic                         rq_ready,
  input  logic [CW-1:0]                rq_x,
  input  logic [RW-1:0]                rq_y,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIN*WIN*CH*D_SIZE-1:0] rsp_window
);

  localparam int NB    = WIN * WIN;
  localparam int PW    = CH * D_SIZE;
  localparam int BW    = (IMG_W + WIN - 1) / WIN;
  localparam int BH    = (IMG_H + WIN - 1) / WIN;
  localparam int DEPTH = BW * BH;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(WIN);
  localparam int BIW   = $clog2(NB);

  iwb_state_e state_q, state_d;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic          release_pending;
  logic          wr_fire, last_px, acc, advance, pipe_empty, rel_req;
  logic [AW-1:0] wa;
  int            qx, qy, x0, y0;

  logic [NB-1:0][PW-1:0] bank_rd, win_nxt;
  logic                  s1_valid;
  logic [SW-1:0]         s1_x0, s1_y0;
`ifdef IWB_ZERO_PAD_EN
  logic [NB-1:0]         mask_d, s1_mask;
`endif

  assign advance    = !rsp_valid || rsp_ready;
  assign rq_ready   = (state_q == FULL) && advance && !release_pending;
  assign acc        = rq_valid && rq_ready;
  assign wr_fire    = wr_valid && wr_ready;
  assign last_px    = (wx == XW'(IMG_W - 1)) && (wy == YW'(IMG_H - 1));
  // an accept this cycle still counts as in flight for the release check
  assign pipe_empty = !s1_valid && !rsp_valid && !acc;
  assign rel_req    = frame_release || release_pending;
  assign wa         = AW'(bank_addr(int'(wx), int'(wy), WIN, BW));

`ifdef IWB_ZERO_PAD_EN
  assign qx = int'($signed(rq_x));
  assign qy = int'($signed(rq_y));
`else
  assign qx = int'(rq_x);
  assign qy = int'(rq_y);
`endif
  // rotation offsets, wrapped into [0,WIN) even for negative origins
  assign x0 = ((qx % WIN) + WIN) % WIN;
  assign y0 = ((qy % WIN) + WIN) % WIN;

  // state and release latch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q         <= FILL;
      release_pending <= 1'b0;
    end else begin
      state_q         <= state_d;
      release_pending <= (state_q == FULL) && rel_req && !pipe_empty;
    end

  // next state and frame-level outputs
  always_comb begin
    state_d    = state_q;
    wr_ready   = 1'b0;
    frame_full = 1'b0;
    case (state_q)
      FILL: begin
        wr_ready = 1'b1;
        if (wr_valid && last_px) state_d = FULL;
      end
      FULL: begin
        frame_full = 1'b1;
        if (rel_req && pipe_empty) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // raster write counters; cleared after the last pixel of the frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wx <= '0;
      wy <= '0;
    end else if (wr_fire) begin
      if (wx == XW'(IMG_W - 1)) begin
        wx <= '0;
        wy <= last_px ? '0 : wy + 1'b1;
      end else begin
        wx <= wx + 1'b1;
      end
    end

  // one bank per (column mod WIN, row mod WIN); each serves exactly one tap
  for (genvar by = 0; by < WIN; by++) begin : g_brow
    for (genvar bx = 0; bx < WIN; bx++) begin : g_bcol
      localparam int B = by * WIN + bx;
      int            col, row;
      logic [AW-1:0] ra;
      logic          we;

      assign we = wr_fire && (bank_sel(int'(wx), WIN) == bx)
                          && (bank_sel(int'(wy), WIN) == by);

      // frame coordinate this bank contributes to the requested window
      always_comb begin
        col = qx + (bx + WIN - x0) % WIN;
        row = qy + (by + WIN - y0) % WIN;
        ra  = AW'(bank_addr(col, row, WIN, BW));
      end

      iwb_bank #(.WIDTH(PW), .DEPTH(DEPTH), .AW(AW)) u_bank (
        .clk   (clk),
        .we    (we),
        .waddr (wa),
        .wdata (wr_data),
        .re    (advance),
        .raddr (ra),
        .rdata (bank_rd[B])
      );
    end
  end

  // un-rotate bank outputs into tap order (and zero out-of-frame taps)
  for (genvar r = 0; r < WIN; r++) begin : g_trow
    for (genvar c = 0; c < WIN; c++) begin : g_tcol
      localparam int T = r * WIN + c;
      logic [BIW-1:0] bi;
      assign bi = BIW'(((int'(s1_y0) + r) % WIN) * WIN + (int'(s1_x0) + c) % WIN);
`ifdef IWB_ZERO_PAD_EN
      assign mask_d[T]  = (qy + r < 0) || (qy + r > IMG_H - 1) ||
                          (qx + c < 0) || (qx + c > IMG_W - 1);
      assign win_nxt[T] = s1_mask[T] ? '0 : bank_rd[bi];
`else
      assign win_nxt[T] = bank_rd[bi];
`endif
    end
  end

  // stage 1: request metadata alongside the registered bank reads
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x0    <= '0;
      s1_y0    <= '0;
`ifdef IWB_ZERO_PAD_EN
      s1_mask  <= '0;
`endif
    end else if (advance) begin
      s1_valid <= acc;
      s1_x0    <= SW'(x0);
      s1_y0    <= SW'(y0);
`ifdef IWB_ZERO_PAD_EN
      s1_mask  <= mask_d;
`endif
    end

  // stage 2: response register, frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_window <= '0;
    end else if (advance) begin
      rsp_valid <= s1_valid;
      if (s1_valid) rsp_window <= win_nxt;
    end

endmodule

// File: tb/tb_interleaved_window_buffer.sv
// Directed bench for interleaved_window_buffer (32x32 frame, WIN=5, CH=1).
module tb_interleaved_window_buffer;

  localparam int WIN    = 5;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int D_SIZE = 16;
  localparam int CH     = 1;
`ifdef IWB_ZERO_PAD_EN
  localparam int CW = 6;
  localparam int RW = 6;
`else
  localparam int CW = 5;
  localparam int RW = 5;
`endif
  localparam int WW = WIN * WIN * CH * D_SIZE;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_valid, wr_ready, frame_full, frame_release;
  logic [CH*D_SIZE-1:0] wr_data;
  logic                rq_valid, rq_ready, rsp_valid, rsp_ready;
  logic [CW-1:0]       rq_x;
  logic [RW-1:0]       rq_y;
  logic [WW-1:0]       rsp_window;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  interleaved_window_buffer #(
    .WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .D_SIZE(D_SIZE), .CH(CH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .frame_full    (frame_full),
    .frame_release (frame_release),
    .rq_valid      (rq_valid),
    .rq_ready      (rq_ready),
    .rq_x          (rq_x),
    .rq_y          (rq_y),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_window    (rsp_window)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(string tag, logic [WW-1:0] obs, logic [WW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame 0: y*32+x ; frame 1: same pattern xor A5A5
  function automatic logic [15:0] pix(int f, int x, int y);
    logic [15:0] v;
    v = 16'(y * IMG_W + x);
    if (f != 0) v = v ^ 16'hA5A5;
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_win(int f, int x, int y);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        if (x + c >= 0 && x + c < IMG_W && y + r >= 0 && y + r < IMG_H)
          w[(r * WIN + c) * D_SIZE +: D_SIZE] = pix(f, x + c, y + r);
    return w;
  endfunction

  task automatic fill(int f);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        wr_valid = 1'b1;
        wr_data  = pix(f, x, y);
        if (x == IMG_W - 1 && y == IMG_H - 1)
          check1("full_before_last", frame_full, 1'b0);
        tick();
      end
    wr_valid = 1'b0;
    check1("full_after_last", frame_full, 1'b1);
    check1("wr_ready_in_full", wr_ready, 1'b0);
  endtask

  // single request with rsp_ready high: response two cycles after the accept
  task automatic req_win(int f, int x, int y, string tag);
    int n;
    rq_x     = CW'(x);
    rq_y     = RW'(y);
    rq_valid = 1'b1;
    n = 0;
    while (!rq_ready && n < 8) begin
      tick();
      n++;
    end
    check1({tag, "_rq_ready"}, rq_ready, 1'b1);
    tick();
    rq_valid = 1'b0;
    check1({tag, "_lat1"}, rsp_valid, 1'b0);
    tick();
    check1({tag, "_valid"}, rsp_valid, 1'b1);
    checkw(tag, rsp_window, exp_win(f, x, y));
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    wr_valid      = 1'b0;
    wr_data       = '0;
    frame_release = 1'b0;
    rq_valid      = 1'b0;
    rq_x          = '0;
    rq_y          = '0;
    rsp_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_wr_ready", wr_ready, 1'b1);
    check1("rst_frame_full", frame_full, 1'b0);
    check1("rst_rq_ready", rq_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    checkw("rst_rsp_window", rsp_window, '0);
    rst = 1'b0;
    tick();

    // partial fill, then reset mid-frame
    for (int i = 0; i < 500; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'hFFFF;
      tick();
    end
    wr_valid = 1'b0;
    check1("partial_not_full", frame_full, 1'b0);
    rst = 1'b1;
    #1;
    check1("midrst_wr_ready", wr_ready, 1'b1);
    check1("midrst_frame_full", frame_full, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    fill(0);
    req_win(0, 0, 0, "win_0_0");
    req_win(0, 7, 13, "win_7_13");
    req_win(0, 27, 27, "win_27_27");

    // back-to-back requests, one window per cycle
    rq_valid = 1'b1;
    rq_x = CW'(0);
    rq_y = RW'(0);
    check1("b2b_rq_ready", rq_ready, 1'b1);
    tick();
    check1("b2b_lat1", rsp_valid, 1'b0);
    rq_x = CW'(1);
    tick();
    check1("b2b_v0", rsp_valid, 1'b1);
    checkw("b2b_w0", rsp_window, exp_win(0, 0, 0));
    rq_x = CW'(2);
    tick();
    rq_valid = 1'b0;
    check1("b2b_v1", rsp_valid, 1'b1);
    checkw("b2b_w1", rsp_window, exp_win(0, 1, 0));
    tick();
    check1("b2b_v2", rsp_valid, 1'b1);
    checkw("b2b_w2", rsp_window, exp_win(0, 2, 0));
    tick();
    check1("b2b_drained", rsp_valid, 1'b0);

    // stall with two outstanding, release pulsed during the stall
    rsp_ready = 1'b0;
    rq_valid  = 1'b1;
    rq_x = CW'(3);
    rq_y = RW'(0);
    tick();
    rq_x = CW'(4);
    tick();
    rq_valid = 1'b0;
    check1("stall_rq_ready", rq_ready, 1'b0);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check1("stall_valid", rsp_valid, 1'b1);
      checkw("stall_window", rsp_window, exp_win(0, 3, 0));
      check1("stall_rq_blocked", rq_ready, 1'b0);
      check1("stall_still_full", frame_full, 1'b1);
      tick();
    end
    rsp_ready = 1'b1;
    check1("pending_rq_blocked", rq_ready, 1'b0);
    tick();
    check1("drain_v1", rsp_valid, 1'b1);
    checkw("drain_w1", rsp_window, exp_win(0, 4, 0));
    tick();
    check1("drain_done", rsp_valid, 1'b0);
    check1("full_until_drained", frame_full, 1'b1);
    tick();
    check1("release_fill", frame_full, 1'b0);
    check1("release_wr_ready", wr_ready, 1'b1);

    // refill with a new pattern: counters must restart at (0,0)
    fill(1);
    req_win(1, 0, 0, "refill_0_0");
    req_win(1, 10, 20, "refill_10_20");
`ifdef IWB_ZERO_PAD_EN
    req_win(1, -2, -2, "pad_m2_m2");
    req_win(1, 30, 29, "pad_30_29");
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
